// File: rtl/gpu_noc_ni_v2.sv
// GPU<->router network interface: ID translation, per-direction FIFO plus output register, drop counters.
// Optional local loopback of self-addressed GPU flits is enabled by defining NI_LOOPBACK_EN.

module gpu_noc_ni_v2_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module gpu_noc_ni_v2 #(
  parameter int GPU_ID      = 29,
  parameter int DATA_W      = 16,
  parameter int ID_W        = 6,
  parameter int NUM_GPUS    = 32,
  parameter int ADDR_OFFSET = 3,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] gpu_data_in,
  input  logic              gpu_valid_in,
  output logic              gpu_ready_out,
  output logic [DATA_W-1:0] gpu_data_out,
  output logic              gpu_valid_out,
  input  logic              gpu_ready_in,
  output logic [DATA_W-1:0] router_data_out,
  output logic              router_valid_out,
  input  logic              router_ready_in,
  input  logic [DATA_W-1:0] router_data_in,
  input  logic              router_valid_in,
  output logic              router_ready_out,
  output logic [CNT_W-1:0]  tx_drop_cnt,
  output logic [CNT_W-1:0]  rx_drop_cnt
);
  localparam int PAY_W = DATA_W - ID_W;
  localparam logic [ID_W-1:0] OFFSET   = ID_W'(ADDR_OFFSET);
  localparam logic [ID_W-1:0] MAX_ID   = ID_W'(NUM_GPUS);
  localparam logic [ID_W-1:0] OWN_ADDR = ID_W'(GPU_ID + ADDR_OFFSET);

  logic [ID_W-1:0]   tx_dest;
  logic [ID_W-1:0]   rx_hdr;
  logic              tx_dest_ok;
  logic              rx_hit;
  logic              gpu_fire;
  logic              router_fire;
  logic              tx_push;
  logic              rx_push;
  logic              tx_pop;
  logic              rx_pop;
  logic              tx_drop;
  logic              rx_drop;
  logic              tx_full;
  logic              tx_empty;
  logic              rx_full;
  logic              rx_empty;
  logic [DATA_W-1:0] tx_push_data;
  logic [DATA_W-1:0] rx_push_data;
  logic [DATA_W-1:0] tx_head;
  logic [DATA_W-1:0] rx_head;

  assign tx_dest     = gpu_data_in[DATA_W-1 -: ID_W];
  assign rx_hdr      = router_data_in[DATA_W-1 -: ID_W];
  assign tx_dest_ok  = (tx_dest != '0) && (tx_dest <= MAX_ID);
  assign rx_hit      = (rx_hdr == OWN_ADDR);

  assign router_ready_out = !rx_full;
  assign gpu_fire         = gpu_valid_in && gpu_ready_out;
  assign router_fire      = router_valid_in && router_ready_out;

  assign tx_push_data = {tx_dest + OFFSET, gpu_data_in[PAY_W-1:0]};
  assign tx_drop      = gpu_fire && !tx_dest_ok;
  assign rx_drop      = router_fire && !rx_hit;

`ifdef NI_LOOPBACK_EN
  logic self_hit;
  assign self_hit = (tx_dest == ID_W'(GPU_ID));
  // Router traffic owns the RX FIFO; a self-addressed GPU flit waits for a quiet router side
  assign gpu_ready_out = !tx_full && !(self_hit && (rx_full || router_valid_in));
  assign tx_push       = gpu_fire && tx_dest_ok && !self_hit;
  assign rx_push       = (router_fire && rx_hit) || (gpu_fire && self_hit);
  assign rx_push_data  = (router_fire && rx_hit) ? {rx_hdr - OFFSET, router_data_in[PAY_W-1:0]}
                                                 : gpu_data_in;
`else
  assign gpu_ready_out = !tx_full;
  assign tx_push       = gpu_fire && tx_dest_ok;
  assign rx_push       = router_fire && rx_hit;
  assign rx_push_data  = {rx_hdr - OFFSET, router_data_in[PAY_W-1:0]};
`endif

  gpu_noc_ni_v2_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (tx_push_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .empty     (tx_empty),
    .full      (tx_full)
  );

  gpu_noc_ni_v2_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_push_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .empty     (rx_empty),
    .full      (rx_full)
  );

  // Output registers refill from the FIFO head whenever they are free or being drained
  assign tx_pop = !tx_empty && (!router_valid_out || router_ready_in);
  assign rx_pop = !rx_empty && (!gpu_valid_out || gpu_ready_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      router_valid_out <= 1'b0;
      router_data_out  <= '0;
    end else if (tx_pop) begin
      router_valid_out <= 1'b1;
      router_data_out  <= tx_head;
    end else if (router_ready_in) begin
      router_valid_out <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpu_valid_out <= 1'b0;
      gpu_data_out  <= '0;
    end else if (rx_pop) begin
      gpu_valid_out <= 1'b1;
      gpu_data_out  <= rx_head;
    end else if (gpu_ready_in) begin
      gpu_valid_out <= 1'b0;
    end
  end

  // Drop counters stick at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_drop_cnt <= '0;
      rx_drop_cnt <= '0;
    end else begin
      if (tx_drop && (tx_drop_cnt != '1)) begin
        tx_drop_cnt <= tx_drop_cnt + 1'b1;
      end
      if (rx_drop && (rx_drop_cnt != '1)) begin
        rx_drop_cnt <= rx_drop_cnt + 1'b1;
      end
    end
  end
endmodule
